fft4_frame_sched: RTL and testbench



---
 rtl/fft4_sched_pkg.sv | 24 ++
 rtl/fft4_frame_buf.sv | 41 ++++
 rtl/fft4_frame_sched.sv | 171 +++++++++++++++++
 tb/tb_fft4_frame_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft4_sched_pkg.sv
// Shared types and constants for the fft4 frame scheduler.
// FRAME_LEN   : samples per frame (fixed by the 4-point core).
// IDX_W       : width of the in-frame sample/bin index.
// sched_state_t : scheduler FSM states.
// frame_idx_t : in-frame index type.
// frame_t     : 4-entry sample array at the default 32-bit sample width.
package fft4_sched_pkg;

    localparam int FRAME_LEN = 4;
    localparam int IDX_W     = 2;
    localparam int SAMPLE_W  = 32;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } sched_state_t;

    typedef logic [IDX_W-1:0] frame_idx_t;

    typedef logic [FRAME_LEN-1:0][SAMPLE_W-1:0] frame_t;

endpackage

// File: rtl/fft4_frame_buf.sv
// Four-entry register file holding one frame of samples or results.
// clk       : clock, rising edge.
// rst       : synchronous active-low reset; clears every entry.
// we_i      : write one entry at widx_i with wdata_i.
// widx_i    : entry index for a single write.
// wdata_i   : single-write data.
// ld_i      : load all four entries from ld_data_i at once (wins over we_i).
// ld_data_i : parallel load data, entry k in slice [k].
// rd_o      : parallel read of all four entries.
module fft4_frame_buf
    import fft4_sched_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we_i,
    input  logic [IDX_W-1:0]                    widx_i,
    input  logic [WIDTH-1:0]                    wdata_i,
    input  logic                                ld_i,
    input  logic [FRAME_LEN-1:0][WIDTH-1:0]     ld_data_i,
    output logic [FRAME_LEN-1:0][WIDTH-1:0]     rd_o
);

    logic [FRAME_LEN-1:0][WIDTH-1:0] mem_q;

    // NOTE: this storage is a handful of flops, not a RAM, so clearing it
    // in reset is cheap and keeps the read-out at zero after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= '0;
        end else if (ld_i) begin
            mem_q <= ld_data_i;
        end else if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rd_o = mem_q;

endmodule

// File: rtl/fft4_frame_sched.sv
// Frame scheduler for the 4-point FFT core: gathers four serial samples,
// launches the core with a one-cycle start, holds its inputs until done,
// then streams the four results out with valid/ready.
// s_data/s_valid/s_ready : input sample stream.
// m_data/m_valid/m_ready : result stream; m_idx is the bin, m_last marks bin 3.
// fft_start, fft_in0..3  : launch pulse and frame samples to the core.
// fft_done, fft_out0..3  : core completion pulse and results.
// busy        : high outside FILL.
// err_timeout : sticky, set when the core failed to finish in time.
// frame_count : completed frames, wraps.
module fft4_frame_sched
    import fft4_sched_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [1:0]        m_idx,
    output logic              fft_start,
    output logic [WIDTH-1:0]  fft_in0,
    output logic [WIDTH-1:0]  fft_in1,
    output logic [WIDTH-1:0]  fft_in2,
    output logic [WIDTH-1:0]  fft_in3,
    input  logic              fft_done,
    input  logic [WIDTH-1:0]  fft_out0,
    input  logic [WIDTH-1:0]  fft_out1,
    input  logic [WIDTH-1:0]  fft_out2,
    input  logic [WIDTH-1:0]  fft_out3,
    output logic              busy,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  frame_count
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam frame_idx_t LAST_IDX = frame_idx_t'(FRAME_LEN - 1);

    sched_state_t      state_q, state_d;
    frame_idx_t        fill_idx_q, fill_idx_d;
    frame_idx_t        drain_idx_q, drain_idx_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              s_ready_q, s_ready_d;
    logic              in_we;
    logic              res_ld;

    logic [FRAME_LEN-1:0][WIDTH-1:0] in_rd;
    logic [FRAME_LEN-1:0][WIDTH-1:0] res_rd;

    fft4_frame_buf #(.WIDTH(WIDTH)) u_in_buf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (in_we),
        .widx_i    (fill_idx_q),
        .wdata_i   (s_data),
        .ld_i      (1'b0),
        .ld_data_i ('0),
        .rd_o      (in_rd)
    );

    fft4_frame_buf #(.WIDTH(WIDTH)) u_res_buf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (1'b0),
        .widx_i    ('0),
        .wdata_i   ('0),
        .ld_i      (res_ld),
        .ld_data_i ({fft_out3, fft_out2, fft_out1, fft_out0}),
        .rd_o      (res_rd)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        fill_idx_d  = fill_idx_q;
        drain_idx_d = drain_idx_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        in_we       = 1'b0;
        res_ld      = 1'b0;

        case (state_q)
            FILL: begin
                if (s_valid && s_ready_q) begin
                    in_we      = 1'b1;
                    fill_idx_d = fill_idx_q + frame_idx_t'(1);
                    if (fill_idx_q == LAST_IDX) begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // A done arriving on the last allowed cycle still counts.
                if (fft_done) begin
                    res_ld  = 1'b1;
                    state_d = DRAIN;
                end else if (TIMEOUT_CYCLES != 0 && tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = FILL;
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    drain_idx_d = drain_idx_q + frame_idx_t'(1);
                    if (drain_idx_q == LAST_IDX) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        state_d     = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        // Registered so that s_ready stays low for as long as reset is held.
        s_ready_d = (state_d == FILL);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FILL;
            fill_idx_q  <= '0;
            drain_idx_q <= '0;
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            s_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_idx_q  <= fill_idx_d;
            drain_idx_q <= drain_idx_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            s_ready_q   <= s_ready_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign m_valid     = (state_q == DRAIN);
    assign m_data      = res_rd[drain_idx_q];
    assign m_idx       = drain_idx_q;
    assign m_last      = (state_q == DRAIN) && (drain_idx_q == LAST_IDX);
    assign fft_start   = (state_q == LAUNCH);
    assign fft_in0     = in_rd[0];
    assign fft_in1     = in_rd[1];
    assign fft_in2     = in_rd[2];
    assign fft_in3     = in_rd[3];
    assign busy        = (state_q != FILL);
    assign err_timeout = err_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_fft4_frame_sched.sv
// Directed bench for fft4_frame_sched with a behavioural fft4 stub
// (out_k = 2*in_k, done a programmable number of cycles after start).
module tb_fft4_frame_sched;
    import fft4_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [1:0]  m_idx;
    logic        fft_start;
    logic [31:0] fft_in0, fft_in1, fft_in2, fft_in3;
    logic        fft_done;
    logic [31:0] fft_out0, fft_out1, fft_out2, fft_out3;
    logic        busy;
    logic        err_timeout;
    logic [1:0]  frame_count;

    always #5 clk = ~clk;

    fft4_frame_sched #(.WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .m_idx(m_idx),
        .fft_start(fft_start),
        .fft_in0(fft_in0), .fft_in1(fft_in1), .fft_in2(fft_in2), .fft_in3(fft_in3),
        .fft_done(fft_done),
        .fft_out0(fft_out0), .fft_out1(fft_out1), .fft_out2(fft_out2), .fft_out3(fft_out3),
        .busy(busy), .err_timeout(err_timeout), .frame_count(frame_count)
    );

    // fft4 stub: stub_delay==0 means the core never finishes.
    int   stub_delay = 3;
    int   stub_cnt   = 0;
    logic stub_done  = 1'b0;
    logic spur_done  = 1'b0;
    assign fft_done = stub_done | spur_done;

    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (fft_start) begin
            stub_cnt <= stub_delay;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                stub_done <= 1'b1;
                fft_out0  <= fft_in0 << 1;
                fft_out1  <= fft_in1 << 1;
                fft_out2  <= fft_in2 << 1;
                fft_out3  <= fft_in3 << 1;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] res_d      [4];
    logic [1:0]  res_idx    [4];
    logic        res_last   [4];
    logic        res_stable [4];
    logic        res_busy   [4];

    task automatic push(input logic [31:0] v);
        logic was;
        int   k;
        s_data  = v;
        s_valid = 1'b1;
        for (k = 0; k < 100; k++) begin
            was = s_ready;
            @(posedge clk); #1;
            if (was) break;
        end
        s_valid = 1'b0;
        if (k == 100) begin
            n_checks++;
            $display("FAIL push_accept: sample %0d never accepted, s_ready=%b required 1", v, s_ready);
        end
    endtask

    task automatic push_frame(input int v [4]);
        for (int i = 0; i < 4; i++) push(32'(v[i]));
    endtask

    task automatic get_one(input int slot, input int hold);
        int k;
        k = 0;
        res_stable[slot] = 1'b1;
        while (m_valid !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (m_valid !== 1'b1) begin
            n_checks++;
            $display("FAIL m_valid_wait: m_valid=%b after %0d cycles, required 1", m_valid, k);
            res_d[slot] = 'x; res_idx[slot] = 'x; res_last[slot] = 1'bx; res_busy[slot] = 1'bx;
            return;
        end
        res_d[slot]    = m_data;
        res_idx[slot]  = m_idx;
        res_last[slot] = m_last;
        m_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (m_valid !== 1'b1 || m_data !== res_d[slot] || m_idx !== res_idx[slot])
                res_stable[slot] = 1'b0;
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        res_busy[slot] = busy;
    endtask

    task automatic collect_frame(input int hold);
        for (int i = 0; i < 4; i++) get_one(i, hold);
    endtask

    task automatic cmp_frame(input string name, input int exp [4], input int hold);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (res_d[i] !== 32'(exp[i]) || res_idx[i] !== 2'(i) || res_last[i] !== (i == 3)) begin
                $display("FAIL %s[%0d]: data=%0d idx=%0d last=%b, required data=%0d idx=%0d last=%b",
                         name, i, $signed(res_d[i]), res_idx[i], res_last[i], exp[i], i, (i == 3));
            end else n_pass++;
            if (hold > 0) begin
                n_checks++;
                if (res_stable[i] !== 1'b1)
                    $display("FAIL %s_stable[%0d]: output changed while stalled, required stable", name, i);
                else n_pass++;
            end
            n_checks++;
            if (res_busy[i] !== (i != 3))
                $display("FAIL %s_busy[%0d]: busy=%b after handshake, required %b", name, i, res_busy[i], (i != 3));
            else n_pass++;
        end
    endtask

    task automatic cmp_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %b, required %b", name, got, exp);
        else n_pass++;
    endtask

    task automatic cmp_cnt(input string name, input logic [1:0] exp);
        n_checks++;
        if (frame_count !== exp) $display("FAIL %s: frame_count=%0d, required %0d", name, frame_count, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp_bit("reset_s_ready", s_ready, 1'b0);
        cmp_bit("reset_m_valid", m_valid, 1'b0);
        cmp_bit("reset_busy", busy, 1'b0);
        cmp_bit("reset_fft_start", fft_start, 1'b0);
        cmp_bit("reset_err", err_timeout, 1'b0);
        cmp_cnt("reset_count", 2'd0);
        n_checks++;
        if (m_data !== 32'd0 || fft_in0 !== 32'd0 || fft_in3 !== 32'd0)
            $display("FAIL reset_data: m_data=%0d fft_in0=%0d fft_in3=%0d, required 0", m_data, fft_in0, fft_in3);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        cmp_bit("release_s_ready", s_ready, 1'b1);
    endtask

    task automatic test_basic();
        stub_delay = 3;
        push_frame('{1, 2, 3, 4});
        cmp_bit("basic_start_pulse", fft_start, 1'b1);
        cmp_bit("basic_launch_s_ready", s_ready, 1'b0);
        @(posedge clk); #1;
        cmp_bit("basic_start_drop", fft_start, 1'b0);
        collect_frame(0);
        cmp_frame("basic", '{2, 4, 6, 8}, 0);
        cmp_cnt("basic_count", 2'd1);
    endtask

    task automatic test_backpressure();
        push_frame('{10, 20, 30, 40});
        collect_frame(5);
        cmp_frame("bp", '{20, 40, 60, 80}, 5);
        cmp_cnt("bp_count", 2'd2);
    endtask

    task automatic test_gapped();
        logic   pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        frame_t got;
        frame_t exp;
        logic   leak;
        int     k;
        for (int i = 0; i < 7; i++) begin
            s_valid = pat[i];
            s_data  = 32'(100 + i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        cmp_bit("gap_start_pulse", fft_start, 1'b1);
        got = {fft_in3, fft_in2, fft_in1, fft_in0};
        exp = {32'd106, 32'd104, 32'd103, 32'd100};
        n_checks++;
        if (got !== exp) $display("FAIL gap_capture: fft_in=%h, required %h", got, exp);
        else n_pass++;
        // Offer junk while busy; none of it may be taken.
        s_valid = 1'b1; s_data = 32'd999;
        leak = 1'b0; k = 0;
        while (m_valid !== 1'b1 && k < 50) begin
            if (s_ready !== 1'b0) leak = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        for (int i = 0; i < 4; i++) begin
            if (s_ready !== 1'b0) leak = 1'b1;
            get_one(i, 0);
            if (i < 3 && s_ready !== 1'b0) leak = 1'b1;
        end
        s_valid = 1'b0;
        cmp_bit("gap_no_accept_busy", leak, 1'b0);
        cmp_frame("gap", '{200, 206, 208, 212}, 0);
        cmp_cnt("gap_count", 2'd3);
    endtask

    task automatic test_timeout();
        logic seen_valid;
        stub_delay = 0;
        push_frame('{1, 1, 1, 1});
        seen_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (m_valid !== 1'b0) seen_valid = 1'b1;
        end
        cmp_bit("tmo_still_waiting", busy, 1'b1);
        cmp_bit("tmo_err_not_yet", err_timeout, 1'b0);
        @(posedge clk); #1;
        cmp_bit("tmo_err_set", err_timeout, 1'b1);
        cmp_bit("tmo_back_to_fill", busy, 1'b0);
        cmp_bit("tmo_no_m_valid", seen_valid, 1'b0);
        stub_delay = 3;
        push_frame('{-1, 0, 5, 7});
        collect_frame(0);
        cmp_frame("tmo_next", '{-2, 0, 10, 14}, 0);
        cmp_cnt("tmo_count", 2'd0);
        cmp_bit("tmo_err_sticky", err_timeout, 1'b1);
    endtask

    task automatic test_reset_mid_wait();
        logic bad;
        stub_delay = 7;
        push_frame('{9, 9, 9, 9});
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || fft_start !== 1'b0 ||
            err_timeout !== 1'b0 || frame_count !== 2'd0 || m_last !== 1'b0 || m_idx !== 2'd0 ||
            m_data !== 32'd0 || fft_in0 !== 32'd0)
            $display("FAIL rst_wait_outputs: s_ready=%b m_valid=%b busy=%b start=%b err=%b cnt=%0d last=%b idx=%0d data=%0d in0=%0d, required all 0",
                     s_ready, m_valid, busy, fft_start, err_timeout, frame_count, m_last, m_idx, m_data, fft_in0);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0;
        // The stub's pending done also lands during this window.
        bad = 1'b0;
        repeat (12) begin
            if (m_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        cmp_bit("rst_wait_spurious_done", bad, 1'b0);
        cmp_cnt("rst_wait_count", 2'd0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        stub_delay = 3;
        for (int f = 0; f < 5; f++) begin
            push_frame('{f + 1, f + 2, f + 3, f + 4});
            collect_frame(0);
            n_checks++;
            if (res_d[3] !== 32'(2 * (f + 4)) || frame_count !== exp_cnt[f])
                $display("FAIL wrap_frame%0d: last=%0d count=%0d, required last=%0d count=%0d",
                         f, res_d[3], frame_count, 2 * (f + 4), exp_cnt[f]);
            else n_pass++;
        end
    endtask

    task automatic test_done_at_timeout();
        stub_delay = 7;
        push_frame('{3, 5, 7, 9});
        collect_frame(0);
        cmp_frame("done_tmo", '{6, 10, 14, 18}, 0);
        cmp_bit("done_tmo_no_err", err_timeout, 1'b0);
        cmp_cnt("done_tmo_count", 2'd2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gapped();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_done_at_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
